// File: rtl/io_bcd_display.sv
// io_bcd_display: decimal 7-segment output stage for the processor OUT path.
// A 32-bit word strobed on out_valid is converted to BCD by a sequential
// double-dabble engine (32 shift cycles) and written to HEX7..HEX0.
// A one-deep pending slot buffers a value that arrives while busy.
// SIGNED_MODE=1 treats the word as two's complement with HEX7 as the sign digit.
// Optional feature macro: IO_BCD_LZ_BLANK_EN (leading-zero blanking).
module io_bcd_display #(
    parameter int unsigned SIGNED_MODE = 1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        out_valid,
    input  logic [31:0] out_data,
    output logic        busy,
    output logic        disp_done,
    output logic        overrun,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7
);

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegMinus = 7'b0111111;
    localparam logic [6:0] SegE     = 7'b0000110;

    // Number of decimal digits that fit on the display (HEX7 is the sign when signed)
    localparam int NumDigits = (SIGNED_MODE != 0) ? 7 : 8;

`ifdef IO_BCD_LZ_BLANK_EN
    localparam bit LzEn = 1'b1;
`else
    localparam bit LzEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StUpdate} state_e;

    state_e       state_q, state_d;
    logic [31:0]  data_q, data_d;
    logic [31:0]  pend_q, pend_d;
    logic         pend_valid_q, pend_valid_d;
    logic         overrun_q, overrun_d;
    logic         neg_q, neg_d;
    logic [31:0]  mag_q, mag_d;
    logic [39:0]  bcd_q, bcd_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         done_q, done_d;
    logic         hex_we;
    logic [39:0]  bcd_adj;
    logic [6:0]   hex_q [8];
    logic [6:0]   hex_n [8];
    logic         ovf;
    int           msd;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state logic: FSM, pending slot and conversion datapath
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        overrun_d    = overrun_q;
        neg_d        = neg_q;
        mag_d        = mag_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        hex_we       = 1'b0;

        // Any strobe while not idle lands in the pending slot; latest value wins
        if (state_q != StIdle && out_valid) begin
            pend_d       = out_data;
            pend_valid_d = 1'b1;
            if (pend_valid_q) begin
                overrun_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (out_valid) begin
                    data_d       = out_data;
                    pend_valid_d = 1'b0;
                    state_d      = StLoad;
                end else if (pend_valid_q) begin
                    data_d       = pend_q;
                    pend_valid_d = 1'b0;
                    state_d      = StLoad;
                end
            end
            StLoad: begin
                if (SIGNED_MODE != 0 && data_q[31]) begin
                    neg_d = 1'b1;
                    mag_d = ~data_q + 32'd1;
                end else begin
                    neg_d = 1'b0;
                    mag_d = data_q;
                end
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                cnt_d          = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                hex_we  = 1'b1;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Display formatting from the finished BCD value
    always_comb begin
        ovf = (SIGNED_MODE != 0) ? (bcd_q[39:28] != 12'd0) : (bcd_q[39:32] != 8'd0);
        msd = 0;
        for (int i = 0; i < NumDigits; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd = i;
            end
        end
        for (int i = 0; i < 8; i++) begin
            hex_n[i] = SegBlank;
            if (!ovf && i < NumDigits && (!LzEn || i <= msd)) begin
                hex_n[i] = glyph(bcd_q[4*i +: 4]);
            end
        end
        if (ovf) begin
            hex_n[0] = SegE;
        end
        if (SIGNED_MODE != 0 && neg_q) begin
            if (LzEn && !ovf) begin
                // Sign floats to just left of the most significant digit
                for (int i = 1; i < 8; i++) begin
                    if (i == msd + 1) begin
                        hex_n[i] = SegMinus;
                    end
                end
            end else begin
                hex_n[7] = SegMinus;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            data_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            neg_q        <= 1'b0;
            mag_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                hex_q[i] <= SegBlank;
            end
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            overrun_q    <= overrun_d;
            neg_q        <= neg_d;
            mag_q        <= mag_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            if (hex_we) begin
                for (int i = 0; i < 8; i++) begin
                    hex_q[i] <= hex_n[i];
                end
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign disp_done = done_q;
    assign overrun   = overrun_q;
    assign HEX0      = hex_q[0];
    assign HEX1      = hex_q[1];
    assign HEX2      = hex_q[2];
    assign HEX3      = hex_q[3];
    assign HEX4      = hex_q[4];
    assign HEX5      = hex_q[5];
    assign HEX6      = hex_q[6];
    assign HEX7      = hex_q[7];

endmodule
